// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one row at a time,
// builds a 16-sample frame per full pass, debounces on whole frames and
// reports one key code per accepted press.
//
// Ports:
//   clk        system clock (sole domain)
//   rst        synchronous active-high reset
//   col_i      keypad columns, active-low, asynchronous to clk
//   row_o      keypad row drive, active-low, exactly one bit low
//   key_code   code of the last accepted key (0-9, A-D=10-13, '*'=14, '#'=15)
//   key_valid  one-cycle pulse when key_code is updated
//   key_held   high while the accepted key is considered pressed
module keypad_scanner #(
  parameter logic [15:0] SCAN_DIV       = 16'd1000,
  parameter logic [7:0]  DEBOUNCE_SCANS = 8'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_i,
  output logic [3:0] row_o,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_DEB   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_DEB = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  col_s1;
  logic [3:0]  col_s;
  logic [15:0] dwell;
  logic [1:0]  row_idx;
  logic [11:0] frame_acc;   // active-high closures seen on rows 0..2
  logic [3:0]  cand;
  logic [7:0]  cnt;

  logic        row_end_c;
  logic        frame_end_c;
  logic [15:0] frame_c;
  logic [4:0]  nlow_c;
  logic [3:0]  single_code_c;
  logic        none_c;
  logic        single_c;

  // Matrix position (row*4 + col) to key code.
  function automatic logic [3:0] key_map(input logic [3:0] pos);
    logic [3:0] code;
    case (pos)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'd10;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = 4'd11;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = 4'd12;
      4'd12:   code = 4'd14;
      4'd13:   code = 4'd0;
      4'd14:   code = 4'd15;
      default: code = 4'd13;
    endcase
    return code;
  endfunction

  // Frame classification; row 3 is taken straight from the synchroniser so
  // the decision is made in the same cycle as its sample.
  always_comb begin
    row_end_c     = (dwell == SCAN_DIV - 16'd1);
    frame_end_c   = row_end_c && (row_idx == 2'd3);
    frame_c       = {~col_s, frame_acc};
    nlow_c        = 5'd0;
    single_code_c = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_c[i]) begin
        nlow_c        = nlow_c + 5'd1;
        single_code_c = key_map(4'(i));
      end
    end
    none_c   = (nlow_c == 5'd0);
    single_c = (nlow_c == 5'd1);
  end

  // Scanner, synchroniser and debounce FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1    <= 4'hF;
      col_s     <= 4'hF;
      dwell     <= 16'd0;
      row_idx   <= 2'd0;
      row_o     <= 4'b1110;
      frame_acc <= 12'd0;
      cand      <= 4'd0;
      cnt       <= 8'd0;
      state     <= IDLE;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      col_s1    <= col_i;
      col_s     <= col_s1;
      key_valid <= 1'b0;

      if (row_end_c) begin
        dwell   <= 16'd0;
        row_idx <= row_idx + 2'd1;
        row_o   <= {row_o[2:0], row_o[3]};
        case (row_idx)
          2'd0:    frame_acc[3:0]  <= ~col_s;
          2'd1:    frame_acc[7:4]  <= ~col_s;
          2'd2:    frame_acc[11:8] <= ~col_s;
          default: ;
        endcase
      end else begin
        dwell <= dwell + 16'd1;
      end

      if (frame_end_c) begin
        case (state)
          IDLE: begin
            if (single_c) begin
              if (DEBOUNCE_SCANS <= 8'd1) begin
                key_code  <= single_code_c;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= PRESSED;
              end else begin
                cand  <= single_code_c;
                cnt   <= 8'd1;
                state <= PRESS_DEB;
              end
            end
          end
          PRESS_DEB: begin
            if (single_c && (single_code_c == cand)) begin
              if (cnt + 8'd1 >= DEBOUNCE_SCANS) begin
                cnt       <= DEBOUNCE_SCANS;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= PRESSED;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end else if (single_c) begin
              cand <= single_code_c;
              cnt  <= 8'd1;
            end else begin
              state <= IDLE;
            end
          end
          PRESSED: begin
            // Extra keys while held are ignored: no rollover.
            if (none_c) begin
              if (DEBOUNCE_SCANS <= 8'd1) begin
                key_held <= 1'b0;
                state    <= IDLE;
              end else begin
                cnt   <= 8'd1;
                state <= RELEASE_DEB;
              end
            end
          end
          RELEASE_DEB: begin
            if (none_c) begin
              if (cnt + 8'd1 >= DEBOUNCE_SCANS) begin
                cnt      <= DEBOUNCE_SCANS;
                key_held <= 1'b0;
                state    <= IDLE;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end else begin
              state <= PRESSED;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, frame-level behavioural
// reference (run lengths of identical frame classes) compared every cycle,
// directed scenarios with literal expectations, then randomized frames.
module tb_keypad_scanner;

  localparam logic [15:0] SCAN_DIV = 16'd4;
  localparam logic [7:0]  DEB      = 8'd2;
  localparam int          FRAME    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_i;
  logic [3:0]  row_o;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = 16'd0;   // bit r*4+c = key at row r, column c closed

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_i     (col_i),
    .row_o     (row_o),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Keypad: a closed key pulls its column low while its row is driven low.
  always_comb begin
    col_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row_o[r] == 1'b0 && keys[r*4+c]) col_i[c] = 1'b0;
  end

  // Reference model.
  int km [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  bit         m_on = 1'b0;
  int         t = 0;
  logic       m_held = 1'b0;
  logic [3:0] m_code = 4'd0;
  logic       m_valid = 1'b0;
  int         run_len = 0;
  int         run_tag = -1;
  int         n_set;
  int         code_tmp;
  int         tag_tmp;
  int         len_tmp;

  always @(posedge clk) begin
    if (rst) begin
      m_on    <= 1'b1;
      t       <= 0;
      m_held  <= 1'b0;
      m_code  <= 4'd0;
      m_valid <= 1'b0;
      run_len <= 0;
      run_tag <= -1;
    end else if (m_on) begin
      t       <= t + 1;
      m_valid <= 1'b0;
      if ((t + 1) % FRAME == 0) begin
        n_set    = $countones(keys);
        code_tmp = 0;
        for (int i = 0; i < 16; i++) if (keys[i]) code_tmp = km[i];
        tag_tmp  = (n_set == 0) ? 100 : ((n_set == 1) ? code_tmp : 200);
        len_tmp  = (run_len > 0 && tag_tmp == run_tag) ? run_len + 1 : 1;
        run_tag <= tag_tmp;
        run_len <= len_tmp;
        if (!m_held && n_set == 1 && len_tmp == int'(DEB)) begin
          m_code  <= 4'(code_tmp);
          m_valid <= 1'b1;
          m_held  <= 1'b1;
        end else if (m_held && n_set == 0 && len_tmp == int'(DEB)) begin
          m_held <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
  endtask

  // Per-cycle comparison against the model.
  logic [3:0] exp_row;
  always @(negedge clk) begin
    if (m_on) begin
      exp_row = 4'b1111 ^ (4'b0001 << ((t / 4) % 4));
      chk("row_o", 32'(row_o), 32'(exp_row));
      chk("key_valid", 32'(key_valid), 32'(m_valid));
      chk("key_code", 32'(key_code), 32'(m_code));
      chk("key_held", 32'(key_held), 32'(m_held));
      if (key_valid === 1'b1) pulses++;
    end
  end

  // Keys change only right after a frame start edge.
  task automatic apply(input logic [15:0] m, input int nf);
    keys = m;
    repeat (nf * FRAME) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_row"}, 32'(row_o), 32'h0000000E);
    chk({tag, "_code"}, 32'(key_code), 32'd0);
    chk({tag, "_valid"}, 32'(key_valid), 32'd0);
    chk({tag, "_held"}, 32'(key_held), 32'd0);
  endtask

  localparam logic [15:0] K1 = 16'h0001, K2 = 16'h0002, K3 = 16'h0004;
  localparam logic [15:0] K5 = 16'h0020, K7 = 16'h0100, K9 = 16'h0400;
  localparam logic [15:0] KSTAR = 16'h1000, KHASH = 16'h4000, KD = 16'h8000;

  initial begin
    int p0;
    int r;
    logic [15:0] m;
    logic [15:0] prev;

    // 1: reset and idle scanning
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_outputs("init");
    p0 = pulses;
    apply(16'd0, 2);
    chk("idle_no_pulse", 32'(pulses - p0), 32'd0);

    // 2: hold '5' then release
    p0 = pulses;
    apply(K5, 6);
    chk("k5_pulses", 32'(pulses - p0), 32'd1);
    chk("k5_code", 32'(key_code), 32'd5);
    chk("k5_held", 32'(key_held), 32'd1);
    apply(16'd0, 3);
    chk("k5_released", 32'(key_held), 32'd0);

    // 3: '#', 'D', '*'
    p0 = pulses;
    apply(KHASH, 3);
    chk("hash_code", 32'(key_code), 32'd15);
    apply(16'd0, 3);
    apply(KD, 3);
    chk("d_code", 32'(key_code), 32'd13);
    apply(16'd0, 3);
    apply(KSTAR, 3);
    chk("star_code", 32'(key_code), 32'd14);
    apply(16'd0, 3);
    chk("three_pulses", 32'(pulses - p0), 32'd3);

    // 4: bouncing '7', then a single-frame glitch
    p0 = pulses;
    apply(K7, 1);
    apply(16'd0, 1);
    apply(K7, 1);
    chk("k7_not_yet", 32'(key_valid), 32'd0);
    apply(K7, 1);
    chk("k7_accept", 32'(key_valid), 32'd1);
    chk("k7_code", 32'(key_code), 32'd7);
    apply(K7, 2);
    apply(16'd0, 3);
    chk("k7_one_pulse", 32'(pulses - p0), 32'd1);
    p0 = pulses;
    apply(K7, 1);
    apply(16'd0, 2);
    chk("glitch_no_pulse", 32'(pulses - p0), 32'd0);

    // 5: two keys from idle, then rollover attempt
    p0 = pulses;
    apply(K1 | K2, 4);
    chk("multi_no_pulse", 32'(pulses - p0), 32'd0);
    apply(16'd0, 1);
    p0 = pulses;
    apply(K3, 3);
    chk("k3_code", 32'(key_code), 32'd3);
    apply(K3 | K9, 3);
    chk("rollover_pulses", 32'(pulses - p0), 32'd1);
    chk("rollover_held", 32'(key_held), 32'd1);
    chk("rollover_code", 32'(key_code), 32'd3);
    apply(16'd0, 3);

    // 6: reset mid PRESS_DEB and mid PRESSED with the key kept closed
    apply(K5, 1);
    repeat (5) @(posedge clk);
    #1;
    do_reset(1);
    chk_reset_outputs("rst_deb");
    apply(K5, 1);
    chk("rst_deb_f1", 32'(key_valid), 32'd0);
    apply(K5, 1);
    chk("rst_deb_f2", 32'(key_valid), 32'd1);
    chk("rst_deb_code", 32'(key_code), 32'd5);
    apply(K5, 2);
    repeat (7) @(posedge clk);
    #1;
    do_reset(1);
    chk_reset_outputs("rst_prs");
    apply(K5, 1);
    chk("rst_prs_f1", 32'(key_valid), 32'd0);
    chk("rst_prs_f1_held", 32'(key_held), 32'd0);
    apply(K5, 1);
    chk("rst_prs_f2", 32'(key_valid), 32'd1);
    chk("rst_prs_f2_held", 32'(key_held), 32'd1);
    apply(16'd0, 3);

    // Randomized frames, with occasional mid-frame resets
    prev = 16'd0;
    for (int f = 0; f < 200; f++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40)      m = prev;
      else if (r < 60) m = 16'd0;
      else if (r < 90) m = 16'(1) << $urandom_range(0, 15);
      else             m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      if ($urandom_range(0, 99) < 3) begin
        keys = m;
        repeat ($urandom_range(1, 15)) @(posedge clk);
        #1;
        do_reset(1);
      end else begin
        apply(m, 1);
      end
      prev = m;
    end

    apply(16'd0, 3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
